mem_if_ctrl: RTL and testbench
==============================

Name: mem_if_ctrl

Overview:
- Processor-side initiator for the tagged main-memory bus: proc2mem_command/addr/data out; mem2proc_response/data/tag in.
- Arbitrates between the I-cache port (P0, loads only) and the D-cache port (P1, loads and stores), issuing at most one bus command per cycle.
- Records which port owns each outstanding load tag. Routes returned data to that port one cycle after the bus returns it.
- Sits between the fetch and LSQ/D-cache side of the core and the memory model in the top-level bench.

Parameters:
- MAX_OUTST, 15, maximum in-flight loads (1..15); tags are 1..15, tag 0 means none.
- CNT_W, 8, width of the saturating unmatched-return counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ic_req_i  in  1  P0 load request, held until accepted
- ic_addr_i  in  64  P0 address
- ic_flush_i  in  1  discard data of all P0 loads outstanding this cycle
- ic_acc_o  out  1  P0 request accepted this cycle
- ic_rsp_vld_o  out  1  P0 data valid (registered)
- ic_rsp_tag_o  out  4  tag of the P0 return
- ic_rsp_data_o  out  64  P0 return data
- dc_req_i  in  1  P1 request, held until accepted
- dc_cmd_i  in  2  1=BUS_LOAD, 2=BUS_STORE (0 and 3 treated as no request)
- dc_addr_i  in  64  P1 address
- dc_data_i  in  64  P1 store data
- dc_acc_o  out  1  P1 request accepted this cycle
- dc_acc_tag_o  out  4  tag granted to the accepted P1 request
- dc_rsp_vld_o  out  1  P1 load data valid (registered)
- dc_rsp_tag_o  out  4  tag of the P1 return
- dc_rsp_data_o  out  64  P1 return data
- proc2mem_command_o  out  2  0=NONE, 1=LOAD, 2=STORE
- proc2mem_addr_o  out  64  bus address
- proc2mem_data_o  out  64  bus store data
- mem2proc_response_i  in  4  same-cycle accept tag; 0 = rejected
- mem2proc_data_i  in  64  returned data
- mem2proc_tag_i  in  4  tag of returned data; 0 = none
- outst_cnt_o  out  4  valid table entries
- unmatched_cnt_o  out  CNT_W  returns with no valid entry (saturating)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: table (valid, owner, drop per tag 1..15) cleared; rr pointer = P1; all registered outputs = 0; unmatched_cnt = 0.
- Bus outputs when idle: proc2mem_command_o = NONE; addr and data = 0.
- Eligibility: a P0 or P1 load is eligible only when outst_cnt < MAX_OUTST. A P1 store is always eligible.
- Arbitration (combinational, same cycle):
  - If exactly one port is eligible, it drives the bus.
  - If both are eligible, the port named by rr drives the bus.
- Acceptance: issued request is accepted iff mem2proc_response_i != 0.
  - The granted port's acc_o pulses for that cycle; dc_acc_tag_o = response.
  - rr flips to the other port only on acceptance.
  - On rejection: no acc, rr unchanged; the requester holds and retries next cycle.
- Table set: an accepted load sets table[response] = {valid=1, owner, drop=0}. Accepted stores create no entry.
- Return (mem2proc_tag_i = T != 0):
  - If table[T] is valid and drop = 0: next cycle the owner's rsp_vld = 1, with rsp_tag = T and data. Entry cleared.
  - If valid and drop = 1: entry cleared; no rsp_vld.
  - If not valid: unmatched_cnt increments, saturating at all-ones; no rsp_vld.
- rsp_vld_o is a single-cycle pulse per return.
- Same-cycle set and clear of the same tag: the clear is applied first, then the set. The new entry survives.
- Flush: ic_flush_i sets drop on all valid P0 entries, including a P0 load accepted in the same cycle.
  - P0 requests presented in the flush cycle are not issued.
  - Flush does not touch P1 entries.
- outst_cnt_o: registered valid-entry count. It reflects sets and clears of cycle N in cycle N+1.
- Reset mid-operation: the table is lost. Returns that arrive after reset count as unmatched; they are not delivered.

Test Plan:
- P0 load of 0x100, memory responds tag 3, data 0xDEAD returned with tag 3 five cycles later -> ic_acc_o pulses in the issue cycle; one cycle after the return, ic_rsp_vld_o=1, ic_rsp_tag_o=3, ic_rsp_data_o=0xDEAD; outst_cnt 0->1->0.
- P0 load and P1 load both requesting for 4 cycles, memory accepting every cycle -> bus grants P1,P0,P1,P0; each acc pulses once per grant.
- P1 store of 0x55 to 0x200, response 7 -> command=2, data=0x55, dc_acc_o=1, dc_acc_tag_o=7; outst_cnt stays 0; a later stray return with tag 7 -> unmatched_cnt=1.
- Memory returns response 0 for 3 cycles, then 2 -> no acc for 3 cycles, rr unchanged; acc pulses on cycle 4 with tag 2.
- Two P0 loads outstanding (tags 1, 2), ic_flush_i pulsed, then both tags return -> no ic_rsp_vld_o; outst_cnt reaches 0.
- MAX_OUTST=2 with two loads outstanding; a P1 load and a P1 store pending -> store issued, load held; after one return the load issues. Also: return of tag 4 and re-accept of tag 4 in the same cycle -> old data delivered next cycle, new entry valid.

Source files
------------

// File: rtl/mem_if_ctrl_if.sv
// mem_if_ctrl_if: bundles the cache-side and bus-side signals of mem_if_ctrl.
//   master : the controller (drives acc/rsp/proc2mem/status, samples requests
//            and mem2proc returns)
//   slave  : the environment (caches plus memory model)
// CNT_W sets the width of the unmatched-return counter.
interface mem_if_ctrl_if #(parameter int CNT_W = 8);
   // P0 (I-cache)
   logic             ic_req_i;
   logic [63:0]      ic_addr_i;
   logic             ic_flush_i;
   logic             ic_acc_o;
   logic             ic_rsp_vld_o;
   logic [3:0]       ic_rsp_tag_o;
   logic [63:0]      ic_rsp_data_o;
   // P1 (D-cache)
   logic             dc_req_i;
   logic [1:0]       dc_cmd_i;
   logic [63:0]      dc_addr_i;
   logic [63:0]      dc_data_i;
   logic             dc_acc_o;
   logic [3:0]       dc_acc_tag_o;
   logic             dc_rsp_vld_o;
   logic [3:0]       dc_rsp_tag_o;
   logic [63:0]      dc_rsp_data_o;
   // memory bus
   logic [1:0]       proc2mem_command_o;
   logic [63:0]      proc2mem_addr_o;
   logic [63:0]      proc2mem_data_o;
   logic [3:0]       mem2proc_response_i;
   logic [63:0]      mem2proc_data_i;
   logic [3:0]       mem2proc_tag_i;
   // status
   logic [3:0]       outst_cnt_o;
   logic [CNT_W-1:0] unmatched_cnt_o;

   modport master (
      input  ic_req_i, ic_addr_i, ic_flush_i,
      output ic_acc_o, ic_rsp_vld_o, ic_rsp_tag_o, ic_rsp_data_o,
      input  dc_req_i, dc_cmd_i, dc_addr_i, dc_data_i,
      output dc_acc_o, dc_acc_tag_o, dc_rsp_vld_o, dc_rsp_tag_o, dc_rsp_data_o,
      output proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
      input  mem2proc_response_i, mem2proc_data_i, mem2proc_tag_i,
      output outst_cnt_o, unmatched_cnt_o
   );

   modport slave (
      output ic_req_i, ic_addr_i, ic_flush_i,
      input  ic_acc_o, ic_rsp_vld_o, ic_rsp_tag_o, ic_rsp_data_o,
      output dc_req_i, dc_cmd_i, dc_addr_i, dc_data_i,
      input  dc_acc_o, dc_acc_tag_o, dc_rsp_vld_o, dc_rsp_tag_o, dc_rsp_data_o,
      input  proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
      output mem2proc_response_i, mem2proc_data_i, mem2proc_tag_i,
      input  outst_cnt_o, unmatched_cnt_o
   );
endinterface

// File: rtl/mem_if_ctrl.sv
// mem_if_ctrl: processor-side initiator for the tagged main-memory bus.
// Arbitrates I-cache loads (P0) and D-cache loads/stores (P1) onto one bus
// command per cycle, records the owner of each outstanding load tag and
// routes returned data to that owner one cycle after the bus returns it.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - mem_if_ctrl_if.master: cache request/response, proc2mem/mem2proc
//          bus and outst/unmatched status counters
module mem_if_ctrl #(
   parameter int MAX_OUTST = 15,
   parameter int CNT_W     = 8
) (
   input  logic          clk,
   input  logic          rst,
   mem_if_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_LOAD  = 2'd1,
      CMD_STORE = 2'd2
   } bus_cmd_e;

   localparam logic RR_P0 = 1'b0;
   localparam logic RR_P1 = 1'b1;

   // Tag table, one bit per tag 1..15. own: 0 = P0, 1 = P1.
   logic [15:1] tbl_vld, tbl_own, tbl_drop;
   logic [15:1] vld_nxt, own_nxt, drop_nxt;
   logic [3:0]  cnt_nxt;

   logic             rr_q;
   logic [3:0]       outst_q;
   logic [CNT_W-1:0] unm_q;

   logic        ic_rsp_vld_q, dc_rsp_vld_q;
   logic [3:0]  ic_rsp_tag_q, dc_rsp_tag_q;
   logic [63:0] ic_rsp_data_q, dc_rsp_data_q;

   logic       room, ic_elig, dc_ld, dc_st, dc_elig;
   logic       gnt_ic, gnt_dc, acc, load_acc;
   logic [3:0] rsp_tag, ret_tag;
   logic       ret_hit, ret_miss, deliver;

   // ---------------- arbitration ----------------
   always_comb begin
      room    = outst_q < 4'(MAX_OUTST);
      // P0 requests are suppressed while flushing so nothing new escapes the flush
      ic_elig = bus.ic_req_i && !bus.ic_flush_i && room;
      dc_ld   = bus.dc_req_i && (bus.dc_cmd_i == CMD_LOAD);
      dc_st   = bus.dc_req_i && (bus.dc_cmd_i == CMD_STORE);
      dc_elig = dc_st || (dc_ld && room);
      gnt_dc  = dc_elig && (!ic_elig || rr_q == RR_P1);
      gnt_ic  = ic_elig && !gnt_dc;
      rsp_tag = bus.mem2proc_response_i;
      acc     = (gnt_ic || gnt_dc) && (rsp_tag != 4'd0);
      load_acc = acc && !(gnt_dc && dc_st);

      bus.proc2mem_command_o = CMD_NONE;
      bus.proc2mem_addr_o    = '0;
      bus.proc2mem_data_o    = '0;
      if (gnt_ic) begin
         bus.proc2mem_command_o = CMD_LOAD;
         bus.proc2mem_addr_o    = bus.ic_addr_i;
      end else if (gnt_dc) begin
         bus.proc2mem_command_o = dc_st ? CMD_STORE : CMD_LOAD;
         bus.proc2mem_addr_o    = bus.dc_addr_i;
         if (dc_st) bus.proc2mem_data_o = bus.dc_data_i;
      end
   end

   assign bus.ic_acc_o     = acc && gnt_ic;
   assign bus.dc_acc_o     = acc && gnt_dc;
   assign bus.dc_acc_tag_o = (acc && gnt_dc) ? rsp_tag : 4'd0;

   // ---------------- return lookup and table update ----------------
   always_comb begin
      ret_tag  = bus.mem2proc_tag_i;
      ret_hit  = (ret_tag != 4'd0) && tbl_vld[ret_tag];
      ret_miss = (ret_tag != 4'd0) && !tbl_vld[ret_tag];
      // a P0 load returning in a flush cycle is still outstanding, so it is discarded too
      deliver  = ret_hit && !tbl_drop[ret_tag] && !(bus.ic_flush_i && !tbl_own[ret_tag]);

      vld_nxt  = tbl_vld;
      own_nxt  = tbl_own;
      drop_nxt = tbl_drop;
      // clear before set so a tag recycled in the same cycle keeps its new entry
      if (ret_hit) vld_nxt[ret_tag] = 1'b0;
      if (load_acc) begin
         vld_nxt[rsp_tag]  = 1'b1;
         own_nxt[rsp_tag]  = gnt_dc;
         drop_nxt[rsp_tag] = 1'b0;
      end
      if (bus.ic_flush_i) begin
         for (int t = 1; t < 16; t++)
            if (vld_nxt[t] && !own_nxt[t]) drop_nxt[t] = 1'b1;
      end

      cnt_nxt = 4'd0;
      for (int t = 1; t < 16; t++) cnt_nxt = cnt_nxt + 4'(vld_nxt[t]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_vld       <= '0;
         tbl_own       <= '0;
         tbl_drop      <= '0;
         rr_q          <= RR_P1;
         outst_q       <= 4'd0;
         unm_q         <= '0;
         ic_rsp_vld_q  <= 1'b0;
         ic_rsp_tag_q  <= 4'd0;
         ic_rsp_data_q <= '0;
         dc_rsp_vld_q  <= 1'b0;
         dc_rsp_tag_q  <= 4'd0;
         dc_rsp_data_q <= '0;
      end else begin
         tbl_vld  <= vld_nxt;
         tbl_own  <= own_nxt;
         tbl_drop <= drop_nxt;
         outst_q  <= cnt_nxt;
         // pointer moves to the port that did not just win
         if (acc) rr_q <= gnt_dc ? RR_P0 : RR_P1;
         if (ret_miss && (unm_q != '1)) unm_q <= unm_q + 1'b1;

         ic_rsp_vld_q  <= deliver && !tbl_own[ret_tag];
         ic_rsp_tag_q  <= (deliver && !tbl_own[ret_tag]) ? ret_tag : 4'd0;
         ic_rsp_data_q <= (deliver && !tbl_own[ret_tag]) ? bus.mem2proc_data_i : '0;
         dc_rsp_vld_q  <= deliver && tbl_own[ret_tag];
         dc_rsp_tag_q  <= (deliver && tbl_own[ret_tag]) ? ret_tag : 4'd0;
         dc_rsp_data_q <= (deliver && tbl_own[ret_tag]) ? bus.mem2proc_data_i : '0;
      end
   end

   assign bus.ic_rsp_vld_o    = ic_rsp_vld_q;
   assign bus.ic_rsp_tag_o    = ic_rsp_tag_q;
   assign bus.ic_rsp_data_o   = ic_rsp_data_q;
   assign bus.dc_rsp_vld_o    = dc_rsp_vld_q;
   assign bus.dc_rsp_tag_o    = dc_rsp_tag_q;
   assign bus.dc_rsp_data_o   = dc_rsp_data_q;
   assign bus.outst_cnt_o     = outst_q;
   assign bus.unmatched_cnt_o = unm_q;

endmodule

// File: tb/tb_mem_if_ctrl.sv
// tb_mem_if_ctrl: directed vectors, hand-written corner sequences and random
// stimulus for mem_if_ctrl, checked against a tag-table reference model.
module tb_mem_if_ctrl;
   localparam int MAXO = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_if_ctrl_if #(.CNT_W(8)) bus ();
   mem_if_ctrl #(.MAX_OUTST(MAXO), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: owner per tag (-1 free, 0 P0, 1 P1), drop flag, rr, counters
   int   m_own [16];
   bit   m_drop[16];
   bit   m_rr;
   int   m_unm;
   bit   m_icv, m_dcv;
   logic [3:0]  m_ict, m_dct;
   logic [63:0] m_icd, m_dcd;

   // combinational outputs captured by the last step
   logic [1:0] s_cmd;
   logic       s_ic_acc, s_dc_acc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mcount();
      int c = 0;
      for (int t = 1; t < 16; t++) if (m_own[t] >= 0) c++;
      return c;
   endfunction

   task automatic model_reset();
      for (int t = 0; t < 16; t++) begin m_own[t] = -1; m_drop[t] = 0; end
      m_rr = 1; m_unm = 0; m_icv = 0; m_dcv = 0;
   endtask

   task automatic check_regs();
      chk("ic_rsp_vld", bus.ic_rsp_vld_o, m_icv);
      chk("dc_rsp_vld", bus.dc_rsp_vld_o, m_dcv);
      if (m_icv) begin
         chk("ic_rsp_tag", bus.ic_rsp_tag_o, m_ict);
         chk("ic_rsp_data", bus.ic_rsp_data_o, m_icd);
      end
      if (m_dcv) begin
         chk("dc_rsp_tag", bus.dc_rsp_tag_o, m_dct);
         chk("dc_rsp_data", bus.dc_rsp_data_o, m_dcd);
      end
      chk("outst_cnt", bus.outst_cnt_o, 64'(mcount()));
      chk("unmatched_cnt", bus.unmatched_cnt_o, 64'(m_unm));
   endtask

   task automatic do_reset();
      bus.ic_req_i = 0; bus.ic_addr_i = 0; bus.ic_flush_i = 0;
      bus.dc_req_i = 0; bus.dc_cmd_i = 0; bus.dc_addr_i = 0; bus.dc_data_i = 0;
      bus.mem2proc_response_i = 0; bus.mem2proc_data_i = 0; bus.mem2proc_tag_i = 0;
      rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      check_regs();
      chk("rst_ic_rsp_tag", bus.ic_rsp_tag_o, 0);
      chk("rst_dc_rsp_data", bus.dc_rsp_data_o, 0);
      chk("rst_idle_cmd", bus.proc2mem_command_o, 0);
      chk("rst_idle_addr", bus.proc2mem_addr_o, 0);
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance the
   // model, clock, check registered outputs. Called at posedge+1.
   task automatic step(input logic ic, input logic [63:0] ia, input logic fl,
                       input logic dc, input logic [1:0] dcmd, input logic [63:0] da,
                       input logic [63:0] dd, input logic [3:0] resp,
                       input logic [3:0] rt, input logic [63:0] rdat);
      int cnt, g;
      bit room, ie, de, a;
      logic [1:0]  ecmd;
      logic [63:0] eaddr, edata;
      bus.ic_req_i = ic; bus.ic_addr_i = ia; bus.ic_flush_i = fl;
      bus.dc_req_i = dc; bus.dc_cmd_i = dcmd; bus.dc_addr_i = da; bus.dc_data_i = dd;
      bus.mem2proc_response_i = resp; bus.mem2proc_tag_i = rt; bus.mem2proc_data_i = rdat;
      #4;
      cnt  = mcount();
      room = cnt < MAXO;
      ie   = ic && !fl && room;
      de   = dc && (dcmd == 2 || (dcmd == 1 && room));
      g    = 0;
      if (ie && de) g = m_rr ? 2 : 1;
      else if (ie)  g = 1;
      else if (de)  g = 2;
      ecmd  = (g == 1) ? 2'd1 : (g == 2) ? dcmd : 2'd0;
      eaddr = (g == 1) ? ia : (g == 2) ? da : 64'd0;
      edata = (g == 2 && dcmd == 2) ? dd : 64'd0;
      a     = (g != 0) && (resp != 0);
      s_cmd = bus.proc2mem_command_o; s_ic_acc = bus.ic_acc_o; s_dc_acc = bus.dc_acc_o;
      chk("bus_cmd", bus.proc2mem_command_o, ecmd);
      chk("bus_addr", bus.proc2mem_addr_o, eaddr);
      chk("bus_data", bus.proc2mem_data_o, edata);
      chk("ic_acc", bus.ic_acc_o, a && g == 1);
      chk("dc_acc", bus.dc_acc_o, a && g == 2);
      chk("dc_acc_tag", bus.dc_acc_tag_o, (a && g == 2) ? resp : 4'd0);

      m_icv = 0; m_dcv = 0;
      if (rt != 0) begin
         if (m_own[rt] >= 0) begin
            if (!m_drop[rt] && !(fl && m_own[rt] == 0)) begin
               if (m_own[rt] == 0) begin m_icv = 1; m_ict = rt; m_icd = rdat; end
               else                begin m_dcv = 1; m_dct = rt; m_dcd = rdat; end
            end
            m_own[rt] = -1;
         end else if (m_unm < 255) m_unm++;
      end
      if (a && !(g == 2 && dcmd == 2)) begin m_own[resp] = g - 1; m_drop[resp] = 0; end
      if (fl) for (int t = 1; t < 16; t++) if (m_own[t] == 0) m_drop[t] = 1;
      if (a) m_rr = (g == 1);

      @(posedge clk); #1;
      check_regs();
   endtask

   task automatic idle(input logic [3:0] rt, input logic [63:0] rdat);
      step(0, 0, 0, 0, 0, 0, 0, 0, rt, rdat);
   endtask

   typedef struct packed {
      logic ic; logic dc; logic [1:0] cmd; logic [3:0] resp; logic [3:0] rt;
      logic [1:0] ecmd; logic eic; logic edc; logic [3:0] ecnt;
   } vec_t;
   vec_t vt [17];

   initial begin
      int rt, rs, pick;
      int live [$];

      vt[0]  = '{1'b1,1'b1,2'd1,4'd1,4'd0, 2'd1,1'b0,1'b1,4'd1};
      vt[1]  = '{1'b1,1'b1,2'd1,4'd2,4'd0, 2'd1,1'b1,1'b0,4'd2};
      vt[2]  = '{1'b1,1'b1,2'd1,4'd3,4'd0, 2'd1,1'b0,1'b1,4'd3};
      vt[3]  = '{1'b1,1'b1,2'd1,4'd4,4'd0, 2'd1,1'b1,1'b0,4'd4};
      vt[4]  = '{1'b1,1'b1,2'd1,4'd5,4'd0, 2'd0,1'b0,1'b0,4'd4};
      vt[5]  = '{1'b0,1'b1,2'd2,4'd7,4'd0, 2'd2,1'b0,1'b1,4'd4};
      vt[6]  = '{1'b1,1'b1,2'd1,4'd0,4'd1, 2'd0,1'b0,1'b0,4'd3};
      vt[7]  = '{1'b1,1'b1,2'd1,4'd0,4'd0, 2'd1,1'b0,1'b0,4'd3};
      vt[8]  = '{1'b1,1'b1,2'd1,4'd0,4'd0, 2'd1,1'b0,1'b0,4'd3};
      vt[9]  = '{1'b1,1'b1,2'd1,4'd1,4'd0, 2'd1,1'b1,1'b0,4'd4};
      vt[10] = '{1'b0,1'b1,2'd1,4'd0,4'd2, 2'd0,1'b0,1'b0,4'd3};
      vt[11] = '{1'b0,1'b1,2'd1,4'd5,4'd0, 2'd1,1'b0,1'b1,4'd4};
      vt[12] = '{1'b0,1'b0,2'd0,4'd0,4'd1, 2'd0,1'b0,1'b0,4'd3};
      vt[13] = '{1'b0,1'b0,2'd0,4'd0,4'd3, 2'd0,1'b0,1'b0,4'd2};
      vt[14] = '{1'b0,1'b0,2'd0,4'd0,4'd4, 2'd0,1'b0,1'b0,4'd1};
      vt[15] = '{1'b0,1'b0,2'd0,4'd0,4'd5, 2'd0,1'b0,1'b0,4'd0};
      vt[16] = '{1'b0,1'b0,2'd0,4'd0,4'd7, 2'd0,1'b0,1'b0,4'd0};

      // single P0 load, return five cycles later
      do_reset();
      step(1, 64'h100, 0, 0, 0, 0, 0, 4'd3, 0, 0);
      chk("tp1_ic_acc", s_ic_acc, 1);
      chk("tp1_cmd", s_cmd, 1);
      chk("tp1_cnt_1", bus.outst_cnt_o, 1);
      for (int i = 0; i < 4; i++) idle(0, 0);
      idle(4'd3, 64'hDEAD);
      chk("tp1_rsp_vld", bus.ic_rsp_vld_o, 1);
      chk("tp1_rsp_tag", bus.ic_rsp_tag_o, 3);
      chk("tp1_rsp_data", bus.ic_rsp_data_o, 64'hDEAD);
      chk("tp1_cnt_0", bus.outst_cnt_o, 0);
      idle(0, 0);
      chk("tp1_pulse", bus.ic_rsp_vld_o, 0);

      // arbitration, store, rejection, occupancy limit
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(vt[i].ic, 64'h100, 0, vt[i].dc, vt[i].cmd, 64'h200, 64'h55,
              vt[i].resp, vt[i].rt, 64'hA000 | 64'(vt[i].rt));
         chk("vec_cmd", s_cmd, vt[i].ecmd);
         chk("vec_ic_acc", s_ic_acc, vt[i].eic);
         chk("vec_dc_acc", s_dc_acc, vt[i].edc);
         chk("vec_cnt", bus.outst_cnt_o, vt[i].ecnt);
      end
      chk("vec_unmatched", bus.unmatched_cnt_o, 1);

      // flush discards both outstanding P0 loads
      do_reset();
      step(1, 64'h300, 0, 0, 0, 0, 0, 4'd1, 0, 0);
      step(1, 64'h308, 0, 0, 0, 0, 0, 4'd2, 0, 0);
      step(1, 64'h310, 1, 0, 0, 0, 0, 4'd3, 0, 0);
      chk("fl_no_issue", s_cmd, 0);
      idle(4'd1, 64'h11);
      chk("fl_drop1", bus.ic_rsp_vld_o, 0);
      idle(4'd2, 64'h22);
      chk("fl_drop2", bus.ic_rsp_vld_o, 0);
      chk("fl_cnt", bus.outst_cnt_o, 0);

      // same-cycle return and re-accept of tag 4
      do_reset();
      step(0, 0, 0, 1, 2'd1, 64'h400, 0, 4'd4, 0, 0);
      step(1, 64'h500, 0, 0, 0, 0, 0, 4'd4, 4'd4, 64'hBEEF);
      chk("sc_ic_acc", s_ic_acc, 1);
      chk("sc_dc_vld", bus.dc_rsp_vld_o, 1);
      chk("sc_dc_data", bus.dc_rsp_data_o, 64'hBEEF);
      chk("sc_cnt", bus.outst_cnt_o, 1);
      idle(4'd4, 64'hCAFE);
      chk("sc_ic_vld", bus.ic_rsp_vld_o, 1);
      chk("sc_ic_data", bus.ic_rsp_data_o, 64'hCAFE);

      // reset mid-operation loses the table
      do_reset();
      step(1, 64'h600, 0, 0, 0, 0, 0, 4'd6, 0, 0);
      do_reset();
      idle(4'd6, 64'h66);
      chk("mr_unmatched", bus.unmatched_cnt_o, 1);
      chk("mr_no_rsp", bus.ic_rsp_vld_o, 0);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         live.delete();
         for (int t = 1; t < 16; t++) if (m_own[t] >= 0) live.push_back(t);
         rt   = 0;
         pick = $urandom_range(0, 99);
         if (pick < 40 && live.size() > 0) rt = live[$urandom_range(0, live.size() - 1)];
         else if (pick > 95) rt = $urandom_range(1, 15);
         rs = 0;
         if ($urandom_range(0, 3) != 0) begin
            rs = $urandom_range(1, 15);
            if (m_own[rs] >= 0 && rs != rt) rs = 0;
         end
         step($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), {$urandom, $urandom},
              {$urandom, $urandom}, 4'(rs), 4'(rt), {$urandom, $urandom});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
